// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-boundary registers: stall encodings, mode
// selectors, the NOP payload and the elastic-mode state encoding.
package pipe_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int MODE_STALL   = 0;
  localparam int MODE_ELASTIC = 1;

  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD    = 32'd0;
  localparam logic [7:0]  EXE_NOP_OP   = 8'd0;

  typedef enum logic [1:0] {
    EL_EMPTY = 2'd0,
    EL_FULL  = 2'd1,
    EL_SKID  = 2'd2
  } el_state_e;

  // Packs a NOP instruction the way the stage latches lay out their payload.
  function automatic logic [63:0] nop_payload();
    return {19'd0, EXE_NOP_OP, NOP_REG_ADDR, ZERO_WORD};
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; a clear takes priority over an increment.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// One pipeline boundary: stall-vector latch (MODE 0) or two-entry elastic
// register with skid (MODE 1), plus flush and bubble/hold counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int AUX_W       = 2,
  parameter int STALL_W     = 6,
  parameter int STAGE       = 3,
  parameter int MODE        = 0,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_data_i,
  input  logic [AUX_W-1:0]   aux_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_data_o,
  output logic [AUX_W-1:0]   aux_o,
  input  logic               clr_cnt_i,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   hold_cnt_o
);

  localparam bit HAS_NEXT = (STAGE < STALL_W - 1);
  localparam int NEXT_IDX = HAS_NEXT ? STAGE + 1 : STAGE;
  localparam logic [DATA_W-1:0] NOP_DATA = DATA_W'(nop_payload());

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] skid_d, skid_q;
  logic [AUX_W-1:0]  aux_d, aux_q;
  el_state_e         state_d, state_q;
  logic              in_ready_d, in_ready_q;
  logic              stall_cur, stall_next;
  logic              accept, fire;
  logic              bubble_inc, hold_inc;
  logic [DATA_W-1:0] bubble_data;
  logic              unused_stall;

  assign unused_stall = ^stall_i;
  assign stall_cur    = (stall_i[STAGE] == STOP);
  assign stall_next   = HAS_NEXT ? (stall_i[NEXT_IDX] == STOP) : NO_STOP;
  assign bubble_data  = ZERO_BUBBLE ? NOP_DATA : data_q;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    skid_d     = skid_q;
    aux_d      = aux_q;
    state_d    = state_q;
    in_ready_d = in_ready_q;
    accept     = 1'b0;
    fire       = 1'b0;
    bubble_inc = 1'b0;
    hold_inc   = 1'b0;
    if (MODE == MODE_ELASTIC) begin
      accept     = in_valid_i & in_ready_q;
      fire       = valid_q & out_ready_i;
      bubble_inc = ~valid_q;
      hold_inc   = valid_q & ~out_ready_i;
      aux_d      = accept ? '0 : aux_i;
      if (flush_i) begin
        // Anything accepted alongside the flush is dropped with the rest.
        state_d = EL_EMPTY;
        data_d  = bubble_data;
        aux_d   = '0;
      end else begin
        case (state_q)
          EL_EMPTY: if (accept) begin
            state_d = EL_FULL;
            data_d  = in_data_i;
          end
          EL_FULL: begin
            if (accept && fire) begin
              data_d = in_data_i;
            end else if (accept) begin
              state_d = EL_SKID;
              skid_d  = in_data_i;
            end else if (fire) begin
              state_d = EL_EMPTY;
              data_d  = bubble_data;
            end
          end
          EL_SKID: if (fire) begin
            state_d = EL_FULL;
            data_d  = skid_q;
          end
          default: state_d = EL_EMPTY;
        endcase
      end
      valid_d    = (state_d != EL_EMPTY);
      in_ready_d = (state_d != EL_SKID);
    end else begin
      if (flush_i) begin
        valid_d    = 1'b0;
        data_d     = bubble_data;
        aux_d      = '0;
        bubble_inc = 1'b1;
      end else if (stall_cur && !stall_next) begin
        valid_d    = 1'b0;
        data_d     = bubble_data;
        aux_d      = aux_i;
        bubble_inc = 1'b1;
      end else if (!stall_cur) begin
        valid_d = in_valid_i;
        data_d  = in_data_i;
        aux_d   = '0;
      end else begin
        aux_d    = aux_i;
        hold_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      skid_q     <= '0;
      aux_q      <= '0;
      state_q    <= EL_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      skid_q     <= skid_d;
      aux_q      <= aux_d;
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready_o  = (MODE == MODE_ELASTIC) ? in_ready_q : ~stall_cur;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign aux_o       = aux_q;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .clr   (clr_cnt_i),
    .cnt_o (bubble_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_inc),
    .clr   (clr_cnt_i),
    .cnt_o (hold_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a stall-vector instance with 4-bit counters and an elastic
// instance with default counters, checked against hand-computed values.
module tb_pipe_stage_reg;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Stall-vector instance
  logic [5:0]    a_stall = '0;
  logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0, a_clr = 1'b0;
  logic [DW-1:0] a_in_data = '0;
  logic [1:0]    a_aux_i = '0;
  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_aux_o;
  logic [3:0]    a_bub, a_hold;

  pipe_stage_reg #(.MODE(0), .CNT_W(4)) u_m0 (
    .clk(clk), .rst(rst), .stall_i(a_stall), .flush_i(a_flush),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .aux_i(a_aux_i), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_data_o(a_out_data), .aux_o(a_aux_o), .clr_cnt_i(a_clr),
    .bubble_cnt_o(a_bub), .hold_cnt_o(a_hold)
  );

  // Elastic instance
  logic [5:0]    b_stall = '0;
  logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0, b_clr = 1'b0;
  logic [DW-1:0] b_in_data = '0;
  logic [1:0]    b_aux_i = '0;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_aux_o;
  logic [15:0]   b_bub, b_hold;

  pipe_stage_reg #(.MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .stall_i(b_stall), .flush_i(b_flush),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .aux_i(b_aux_i), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_data_o(b_out_data), .aux_o(b_aux_o), .clr_cnt_i(b_clr),
    .bubble_cnt_o(b_bub), .hold_cnt_o(b_hold)
  );

  logic [DW-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if ({a_out_valid, a_out_data, a_aux_o, a_bub, a_hold} !== '0)
      $display("FAIL reset_m0 got v=%b d=%h aux=%b bub=%0d hold=%0d want all 0", a_out_valid, a_out_data, a_aux_o, a_bub, a_hold); else pass_cnt++;
    total_cnt++; if ({b_out_valid, b_out_data, b_aux_o, b_bub, b_hold} !== '0 || b_in_ready !== 1'b1)
      $display("FAIL reset_m1 got v=%b d=%h aux=%b bub=%0d hold=%0d rdy=%b want 0s rdy=1", b_out_valid, b_out_data, b_aux_o, b_bub, b_hold, b_in_ready); else pass_cnt++;
  endtask

  task automatic test_m0_bubble();
    a_stall = 6'b001000; a_aux_i = 2'b01; a_in_data = 64'hABCD; a_in_valid = 1'b1;
    #1;
    total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL m0_bubble_ready got %b want 0", a_in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0 || a_aux_o !== 2'b01 || a_bub !== 4'd1 || a_hold !== 4'd0)
      $display("FAIL m0_bubble got v=%b d=%h aux=%b bub=%0d hold=%0d want v=0 d=0 aux=01 bub=1 hold=0", a_out_valid, a_out_data, a_aux_o, a_bub, a_hold); else pass_cnt++;
  endtask

  task automatic test_m0_hold();
    a_stall = 6'b000000; a_in_data = 64'h1234; a_aux_i = 2'b10;
    tick();
    total_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h1234 || a_aux_o !== 2'b00)
      $display("FAIL m0_load got v=%b d=%h aux=%b want v=1 d=1234 aux=00", a_out_valid, a_out_data, a_aux_o); else pass_cnt++;
    a_stall = 6'b011000; a_in_data = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      a_aux_i = 2'(i + 1);
      tick();
      total_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h1234 || a_aux_o !== 2'(i + 1))
        $display("FAIL m0_hold_%0d got v=%b d=%h aux=%b want v=1 d=1234 aux=%0d", i, a_out_valid, a_out_data, a_aux_o, i + 1); else pass_cnt++;
    end
    total_cnt++; if (a_hold !== 4'd3 || a_bub !== 4'd1) $display("FAIL m0_hold_cnt got hold=%0d bub=%0d want 3 1", a_hold, a_bub); else pass_cnt++;
    a_stall = 6'b000000; a_in_data = 64'h5678; a_aux_i = 2'b11;
    tick();
    total_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== 64'h5678 || a_aux_o !== 2'b00 || a_hold !== 4'd3)
      $display("FAIL m0_release got v=%b d=%h aux=%b hold=%0d want v=1 d=5678 aux=00 hold=3", a_out_valid, a_out_data, a_aux_o, a_hold); else pass_cnt++;
  endtask

  task automatic test_m0_flush();
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 64'h9999; a_aux_i = 2'b11;
    tick();
    a_flush = 1'b0;
    total_cnt++; if (a_out_valid !== 1'b0 || a_out_data !== 64'h0 || a_aux_o !== 2'b00 || a_bub !== 4'd2)
      $display("FAIL m0_flush got v=%b d=%h aux=%b bub=%0d want v=0 d=0 aux=00 bub=2", a_out_valid, a_out_data, a_aux_o, a_bub); else pass_cnt++;
  endtask

  task automatic test_m0_saturate();
    a_stall = 6'b011000;
    for (int i = 0; i < 20; i++) tick();
    total_cnt++; if (a_hold !== 4'd15) $display("FAIL m0_sat got hold=%0d want 15", a_hold); else pass_cnt++;
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    total_cnt++; if (a_hold !== 4'd0 || a_bub !== 4'd0) $display("FAIL m0_clr got hold=%0d bub=%0d want 0 0", a_hold, a_bub); else pass_cnt++;
    tick();
    total_cnt++; if (a_hold !== 4'd1) $display("FAIL m0_after_clr got hold=%0d want 1", a_hold); else pass_cnt++;
    a_stall = 6'b000000;
  endtask

  task automatic test_m1_stream();
    logic [3:0] rdy_pat;
    int next_val, recv, cyc;
    logic fire, acc;
    rdy_pat = 4'b1001;
    next_val = 1; recv = 0; cyc = 0;
    exp_q.delete();
    while (recv < 8 && cyc < 80) begin
      total_cnt++; if (b_in_ready !== (exp_q.size() < 2) || b_out_valid !== (exp_q.size() > 0))
        $display("FAIL m1_stream_flags cyc=%0d got rdy=%b v=%b occ=%0d", cyc, b_in_ready, b_out_valid, exp_q.size()); else pass_cnt++;
      b_out_ready = rdy_pat[3 - (cyc % 4)];
      fire = b_out_valid && b_out_ready;
      if (fire) begin
        total_cnt++; if (exp_q.size() == 0 || b_out_data !== exp_q[0])
          $display("FAIL m1_stream_data cyc=%0d got %0d want %0d", cyc, b_out_data, (exp_q.size() > 0) ? exp_q[0] : 64'd0); else pass_cnt++;
      end
      acc = (next_val <= 8) && b_in_ready;
      b_in_valid = (next_val <= 8);
      b_in_data  = DW'(next_val);
      tick();
      if (fire && exp_q.size() > 0) begin void'(exp_q.pop_front()); recv++; end
      if (acc) begin exp_q.push_back(DW'(next_val)); next_val++; end
      cyc++;
    end
    b_in_valid = 1'b0;
    total_cnt++; if (recv !== 8 || exp_q.size() !== 0) $display("FAIL m1_stream_done got recv=%0d left=%0d want 8 0", recv, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_m1_flush_skid();
    b_out_ready = 1'b0; b_aux_i = 2'b11;
    b_in_valid = 1'b1; b_in_data = 64'hA1;
    tick();
    total_cnt++; if (b_aux_o !== 2'b00 || b_out_data !== 64'hA1) $display("FAIL m1_accept got aux=%b d=%h want 00 a1", b_aux_o, b_out_data); else pass_cnt++;
    b_in_data = 64'hA2;
    tick();
    b_in_valid = 1'b0;
    total_cnt++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1) $display("FAIL m1_skid got rdy=%b v=%b want 0 1", b_in_ready, b_out_valid); else pass_cnt++;
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0; b_out_ready = 1'b1; b_aux_i = 2'b10;
    total_cnt++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_aux_o !== 2'b00)
      $display("FAIL m1_flush got v=%b rdy=%b aux=%b want 0 1 00", b_out_valid, b_in_ready, b_aux_o); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL m1_flush_quiet_%0d got v=%b want 0", i, b_out_valid); else pass_cnt++;
    end
    total_cnt++; if (b_aux_o !== 2'b10) $display("FAIL m1_aux_idle got %b want 10", b_aux_o); else pass_cnt++;
  endtask

  task automatic test_m1_counters();
    b_out_ready = 1'b1;
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    total_cnt++; if (b_bub !== 16'd0 || b_hold !== 16'd0) $display("FAIL m1_clr got bub=%0d hold=%0d want 0 0", b_bub, b_hold); else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++; if (b_bub !== 16'd3) $display("FAIL m1_bubble got %0d want 3", b_bub); else pass_cnt++;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'hC3;
    tick();
    b_in_valid = 1'b0;
    tick(); tick();
    total_cnt++; if (b_bub !== 16'd4 || b_hold !== 16'd2) $display("FAIL m1_hold got bub=%0d hold=%0d want 4 2", b_bub, b_hold); else pass_cnt++;
  endtask

  task automatic test_m1_reset_in_skid();
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 64'hD4;
    tick();
    b_in_valid = 1'b0;
    total_cnt++; if (b_in_ready !== 1'b0) $display("FAIL m1_pre_rst got rdy=%b want 0", b_in_ready); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if ({b_out_valid, b_out_data, b_aux_o, b_bub, b_hold} !== '0 || b_in_ready !== 1'b1)
      $display("FAIL m1_rst_skid got v=%b d=%h aux=%b bub=%0d hold=%0d rdy=%b want 0s rdy=1", b_out_valid, b_out_data, b_aux_o, b_bub, b_hold, b_in_ready); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_m0_bubble();
    test_m0_hold();
    test_m0_flush();
    test_m0_saturate();
    test_m1_stream();
    test_m1_flush_skid();
    test_m1_counters();
    test_m1_reset_in_skid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
